// File: rtl/program_sequencer.sv
// Multi-cycle fetch/latch/execute sequencer: owns the PC and IR and issues a single
// exec_en strobe per instruction, with run, single-step, stop and HALT handling.
module program_sequencer #(
    parameter int         PC_W        = 8,
    parameter int         INSTR_W     = 10,
    parameter int         PROG_LEN    = 64,
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic               step,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               load_PC,
    input  logic [PC_W-1:0]    pc_value,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_en,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               jump_err,
    output logic [15:0]        instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        EXEC,
        STEP_WAIT,
        HALTED
    } state_t;

    localparam logic [PC_W-1:0] LAST_PC    = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W:0]   PROG_LEN_X = (PC_W + 1)'(PROG_LEN);

    state_t state;
    state_t state_next;
    logic   stop_pending;
    logic   halt_word;
    logic   jump_ok;

    assign halt_word = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
    assign jump_ok   = ({1'b0, pc_value} < PROG_LEN_X);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start && !stop) state_next = FETCH;
            FETCH:     state_next = LATCH;
            LATCH:     state_next = halt_word ? HALTED : EXEC;
            EXEC: begin
                if (stop || stop_pending) begin
                    state_next = IDLE;
                end else if (step_mode) begin
                    state_next = STEP_WAIT;
                end else begin
                    state_next = FETCH;
                end
            end
            STEP_WAIT: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (step) begin
                    state_next = FETCH;
                end
            end
            HALTED:    if (start) state_next = FETCH;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_rd = (state == FETCH);
        exec_en = (state == EXEC);
        busy    = (state != IDLE) && (state != HALTED);
        halted  = (state == HALTED);
    end

    // A stop seen mid-instruction is remembered so the current instruction still completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stop_pending <= 1'b0;
        end else if (state == EXEC) begin
            stop_pending <= 1'b0;
        end else if ((state == FETCH || state == LATCH) && stop) begin
            stop_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            jump_err    <= 1'b0;
        end else begin
            jump_err <= 1'b0;
            case (state)
                LATCH: ir <= imem_rdata;
                EXEC: begin
                    instr_count <= instr_count + 16'd1;
                    if (load_PC) begin
                        if (jump_ok) begin
                            pc <= pc_value;
                        end else begin
                            pc       <= '0;
                            jump_err <= 1'b1;
                        end
                    end else begin
                        pc <= (pc == LAST_PC) ? '0 : pc + 1'b1;
                    end
                end
                HALTED: begin
                    if (start) begin
                        pc <= '0;
                        ir <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
